res_st_alloc: RTL

//  Allocation/occupancy controller for the reservation station (RS) feeding the schedule stage.

---
 rtl/res_st_alloc.sv | 121 ++++++++++++
 1 files changed

// File: rtl/res_st_alloc.sv
// Reservation-station slot allocator: clear walk after reset/flush, in-order dispatch slots, 4-entry issue windows.
// Optional occupancy statistics (hwm, stall_cnt) are built only when RES_ST_STATS_EN is defined.
module res_st_alloc #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WINDOW = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_clear,
  input  logic              win_retire,
  output logic [ADDR_W-1:0] win_base,
  output logic              win_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              retire_err,
  output logic [ADDR_W:0]   hwm,
  output logic [31:0]       stall_cnt
);

  typedef logic [ADDR_W-1:0] res_st_addr_t;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   WIN_C   = (ADDR_W+1)'(WINDOW);
  localparam res_st_addr_t      WIN_A   = ADDR_W'(WINDOW);
  localparam res_st_addr_t      LAST_A  = ADDR_W'(DEPTH - 1);

  state_t       state;
  res_st_addr_t head, tail, clr_ptr;
  logic         run, clearing, xfer, retire_ok, retire_bad, live;
  logic [ADDR_W:0] count_next;

  // Dispatch handshake, write port and window status are combinational from state.
  always_comb begin
    run         = (state == ST_RUN);
    clearing    = !run;
    live        = en && !flush;
    full        = (count == DEPTH_C);
    empty       = (count == '0);
    win_ready   = run && (count >= WIN_C);
    alloc_ready = run && live && !full;
    xfer        = alloc_valid && alloc_ready;
    retire_ok   = run && live && win_retire && (count >= WIN_C);
    retire_bad  = run && live && win_retire && (count < WIN_C);
    wr_en       = en && (clearing || xfer);
    wr_clear    = clearing;
    wr_addr     = clearing ? clr_ptr : tail;
    win_base    = head;
    count_next  = count + (ADDR_W+1)'(xfer) - (retire_ok ? WIN_C : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_INIT;
      head       <= '0;
      tail       <= '0;
      clr_ptr    <= '0;
      count      <= '0;
      retire_err <= 1'b0;
    end else if (en) begin
      if (flush) begin
        state      <= ST_FLUSH;
        head       <= '0;
        tail       <= '0;
        clr_ptr    <= '0;
        count      <= '0;
        retire_err <= 1'b0;
      end else begin
        case (state)
          ST_INIT, ST_FLUSH: begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == LAST_A) begin
              state <= ST_RUN;
              head  <= '0;
              tail  <= '0;
              count <= '0;
            end
          end
          ST_RUN: begin
            if (xfer)       tail       <= tail + 1'b1;
            if (retire_ok)  head       <= head + WIN_A;
            if (retire_bad) retire_err <= 1'b1;
            count <= count_next;
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

`ifdef RES_ST_STATS_EN
  // High-water mark tracks the post-update occupancy; stall counter saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm       <= '0;
      stall_cnt <= '0;
    end else if (en) begin
      if (flush) begin
        hwm       <= '0;
        stall_cnt <= '0;
      end else if (run) begin
        if (count_next > hwm) hwm <= count_next;
        if (alloc_valid && !alloc_ready && (stall_cnt != 32'hFFFF_FFFF))
          stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`else
  assign hwm       = '0;
  assign stall_cnt = '0;
`endif

endmodule
